// File: rtl/mors_pkg.sv
// Shared Morse definitions: element codes, digit pattern constants and receiver FSM states.
package mors_pkg;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Five-element digit patterns, first element in the MSB.
  localparam logic [4:0] PAT_0 = 5'b11111;
  localparam logic [4:0] PAT_1 = 5'b01111;
  localparam logic [4:0] PAT_2 = 5'b00111;
  localparam logic [4:0] PAT_3 = 5'b00011;
  localparam logic [4:0] PAT_4 = 5'b00001;
  localparam logic [4:0] PAT_5 = 5'b00000;
  localparam logic [4:0] PAT_6 = 5'b10000;
  localparam logic [4:0] PAT_7 = 5'b11000;
  localparam logic [4:0] PAT_8 = 5'b11100;
  localparam logic [4:0] PAT_9 = 5'b11110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

endpackage

// File: rtl/mors_pat_decode.sv
// Combinational lookup from a 5-element Morse pattern to a decimal digit.
module mors_pat_decode
  import mors_pkg::*;
(
  input  logic [4:0] pattern,
  output logic [3:0] digit,
  output logic       hit
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    digit = 4'd0;
    hit   = 1'b1;
    case (pattern)
      PAT_0:   digit = 4'd0;
      PAT_1:   digit = 4'd1;
      PAT_2:   digit = 4'd2;
      PAT_3:   digit = 4'd3;
      PAT_4:   digit = 4'd4;
      PAT_5:   digit = 4'd5;
      PAT_6:   digit = 4'd6;
      PAT_7:   digit = 4'd7;
      PAT_8:   digit = 4'd8;
      PAT_9:   digit = 4'd9;
      default: hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mors_to_num.sv
// Serial Morse-to-digit receiver: measures mark/space runs, assembles five
// elements and pulses num_valid or err at each character gap.
module mors_to_num
  import mors_pkg::*;
#(
  parameter int DOT_LEN  = 1,
  parameter int DASH_LEN = 3,
  parameter int CHAR_GAP = 2,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mors,
  output logic [3:0] num,
  output logic       num_valid,
  output logic       err
);

  state_t           state;
  logic [CNT_W-1:0] run;
  logic [4:0]       pattern;
  logic [2:0]       elem_cnt;
  logic             bad;

  logic [CNT_W-1:0] run_inc;
  logic [2:0]       elem_inc;
  logic [3:0]       dec_digit;
  logic             dec_hit;

  assign run_inc  = (run == '1) ? run : run + CNT_W'(1);
  assign elem_inc = (elem_cnt == 3'd7) ? elem_cnt : elem_cnt + 3'd1;

  mors_pat_decode u_pat_decode (
    .pattern (pattern),
    .digit   (dec_digit),
    .hit     (dec_hit)
  );

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run       <= '0;
      pattern   <= '0;
      elem_cnt  <= '0;
      bad       <= 1'b0;
      num       <= '0;
      num_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (mors) begin
            state    <= MARK;
            run      <= CNT_W'(1);
            pattern  <= '0;
            elem_cnt <= '0;
            bad      <= 1'b0;
          end
        end

        MARK: begin
          if (mors) begin
            run <= run_inc;
          end else begin
            // Classify the finished mark; an odd length poisons the whole character.
            if (run == CNT_W'(DOT_LEN)) begin
              pattern <= {pattern[3:0], DOT};
            end else if (run == CNT_W'(DASH_LEN)) begin
              pattern <= {pattern[3:0], DASH};
            end else begin
              bad <= 1'b1;
            end
            if (elem_inc > 3'd5) bad <= 1'b1;
            elem_cnt <= elem_inc;
            state    <= SPACE;
            run      <= CNT_W'(1);
          end
        end

        SPACE: begin
          if (mors) begin
            state <= MARK;
            run   <= CNT_W'(1);
          end else if (run_inc == CNT_W'(CHAR_GAP)) begin
            state <= IDLE;
            run   <= '0;
            if (!bad && elem_cnt == 3'd5 && dec_hit) begin
              num       <= dec_digit;
              num_valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            run <= run_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mors_to_num.sv
// Scoreboard bench for mors_to_num: directed and random characters against a
// mark-length reference model derived from the Morse digit rules.
module tb_mors_to_num;

  localparam int CHAR_GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       mors;
  logic [3:0] num;
  logic       num_valid;
  logic       err;

  typedef struct {
    bit         is_err;
    logic [3:0] digit;
  } exp_t;

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] model_num = 4'd0;

  always #5 clk = ~clk;

  mors_to_num #(.DOT_LEN(1), .DASH_LEN(3), .CHAR_GAP(CHAR_GAP), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mors      (mors),
    .num       (num),
    .num_valid (num_valid),
    .err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Standard Morse digits: 1..5 lead with d dots, 6..9 lead with d-5 dashes, 0 is all dashes.
  function automatic int morse_len(input int d, input int i);
    if (d == 0) return 3;
    if (d <= 5) return (i < d) ? 1 : 3;
    return (i < d - 5) ? 3 : 1;
  endfunction

  function automatic exp_t model(input int m[$]);
    exp_t e;
    e.is_err = 1'b1;
    e.digit  = 4'd0;
    if (m.size() == 5) begin
      for (int d = 0; d < 10; d++) begin
        bit match = 1'b1;
        for (int i = 0; i < 5; i++)
          if (m[i] != morse_len(d, i)) match = 1'b0;
        if (match) begin
          e.is_err = 1'b0;
          e.digit  = d[3:0];
        end
      end
    end
    return e;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    mors = b;
  endtask

  task automatic send_char(input int m[$], input int gap);
    sbq.push_back(model(m));
    for (int i = 0; i < m.size(); i++) begin
      repeat (m[i]) send_bit(1'b1);
      if (i < m.size() - 1) send_bit(1'b0);
    end
    repeat (gap) send_bit(1'b0);
  endtask

  task automatic send_digit(input int d, input int gap);
    int m[$];
    for (int i = 0; i < 5; i++) m.push_back(morse_len(d, i));
    send_char(m, gap);
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      model_num = 4'd0;
    end else if (num_valid || err) begin
      exp_t e;
      check("exclusive", {31'd0, num_valid & err}, 32'd0);
      check("pulse_expected", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("err_kind", {31'd0, err}, {31'd0, e.is_err});
        if (!e.is_err) begin
          check("num", {28'd0, num}, {28'd0, e.digit});
          model_num = e.digit;
        end else begin
          check("num_hold", {28'd0, num}, {28'd0, model_num});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int m[$];
    rst  = 1'b1;
    mors = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_num", {28'd0, num}, 32'd0);
    check("rst_valid", {31'd0, num_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (2) send_bit(1'b0);

    // Digit 3 with explicit latency and pulse-width checks.
    m = {1, 1, 1, 3, 3};
    send_char(m, CHAR_GAP);
    @(negedge clk);
    check("lat3_valid", {31'd0, num_valid}, 32'd1);
    check("lat3_num", {28'd0, num}, 32'd3);
    check("lat3_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("lat3_width", {31'd0, num_valid}, 32'd0);

    // Loopback of every digit, back to back at the minimum gap.
    for (int d = 0; d < 10; d++) send_digit(d, CHAR_GAP);

    // Malformed characters.
    m = {1, 1, 1, 2, 3};       send_char(m, CHAR_GAP);
    m = {1, 1, 1, 1};          send_char(m, CHAR_GAP);
    m = {1, 1, 1, 1, 1, 3};    send_char(m, CHAR_GAP);
    m = {20};                  send_char(m, CHAR_GAP + 1);

    // Back-to-back 5 then 0.
    send_digit(5, CHAR_GAP);
    send_digit(0, CHAR_GAP);

    // Reset after the third element of 8 discards it.
    repeat (3) begin
      repeat (3) send_bit(1'b1);
      send_bit(1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_num", {28'd0, num}, 32'd0);
    check("midrst_valid", {31'd0, num_valid}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_digit(2, CHAR_GAP);

    // Random traffic, mostly legal digits mixed with corrupted characters.
    for (int n = 0; n < 200; n++) begin
      int lead = $urandom_range(0, 3);
      int gap  = CHAR_GAP + $urandom_range(0, 3);
      repeat (lead) send_bit(1'b0);
      if ($urandom_range(0, 9) < 6) begin
        send_digit($urandom_range(0, 9), gap);
      end else begin
        int cnt = $urandom_range(1, 7);
        m = {};
        for (int i = 0; i < cnt; i++) m.push_back($urandom_range(1, 4));
        send_char(m, gap);
      end
    end

    repeat (5) send_bit(1'b0);
    check("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
